// File: rtl/writeback_unit.sv
// writeback_unit: owns the regfile write port. Merges a single-cycle ALU
// stream (priority) with a buffered long-op stream, publishes a
// pending-write mask, and with WB_FORWARD_EN defined adds an operand
// forwarding mux for the write currently in flight.
// REG_ADDR_SIZE / REG_SIZE defaults match the project constants.svh values.
module writeback_unit #(
   parameter int unsigned FIFO_DEPTH    = 4,
   parameter int unsigned STARVE_LIMIT  = 8,
   parameter int unsigned REG_ADDR_SIZE = 5,
   parameter int unsigned REG_SIZE      = 32
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          AluValid,
   input  logic [REG_ADDR_SIZE-1:0]      AluReg,
   input  logic [REG_SIZE-1:0]           AluData,
   output logic                          AluStall,
   input  logic                          LongValid,
   output logic                          LongReady,
   input  logic [REG_ADDR_SIZE-1:0]      LongReg,
   input  logic [REG_SIZE-1:0]           LongData,
   output logic                          WriteEnable,
   output logic [REG_ADDR_SIZE-1:0]      WriteReg,
   output logic [REG_SIZE-1:0]           WriteData,
   output logic [(2**REG_ADDR_SIZE)-1:0] PendingMask
`ifdef WB_FORWARD_EN
   ,
   input  logic [REG_ADDR_SIZE-1:0]      RegA,
   input  logic [REG_ADDR_SIZE-1:0]      RegB,
   input  logic [REG_SIZE-1:0]           Data1,
   input  logic [REG_SIZE-1:0]           Data2,
   output logic [REG_SIZE-1:0]           OpA,
   output logic [REG_SIZE-1:0]           OpB
`endif
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam int unsigned AGE_W = $clog2(STARVE_LIMIT + 1);

   logic [REG_ADDR_SIZE-1:0] fifo_reg  [FIFO_DEPTH];
   logic [REG_SIZE-1:0]      fifo_data [FIFO_DEPTH];
   logic [PTR_W-1:0]         wr_ptr;
   logic [PTR_W-1:0]         rd_ptr;
   logic [CNT_W-1:0]         count;
   logic [AGE_W-1:0]         age;
   logic [AGE_W-1:0]         age_next;
   logic                     fifo_empty;
   logic                     push;
   logic                     pop;
   logic                     alu_take;
   logic [PTR_W-1:0]         slot_off;

   // Handshake and write-source selection; AluStall forces the FIFO head out.
   always_comb begin
      fifo_empty = (count == '0);
      LongReady  = !reset && (count < CNT_W'(FIFO_DEPTH));
      push       = LongValid && LongReady;
      pop        = !fifo_empty && (AluStall || !AluValid);
      alu_take   = AluValid && !pop;
      age_next   = age;
      if (pop || fifo_empty) begin
         age_next = '0;
      end else if (age != AGE_W'(STARVE_LIMIT)) begin
         age_next = age + AGE_W'(1);
      end
   end

   // Control state and registered write port.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         age         <= '0;
         AluStall    <= 1'b0;
         WriteEnable <= 1'b0;
         WriteReg    <= '0;
         WriteData   <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         count       <= count + CNT_W'(push) - CNT_W'(pop);
         age         <= age_next;
         AluStall    <= (age_next == AGE_W'(STARVE_LIMIT));
         WriteEnable <= pop || alu_take;
         if (pop) begin
            WriteReg  <= fifo_reg[rd_ptr];
            WriteData <= fifo_data[rd_ptr];
         end else if (alu_take) begin
            WriteReg  <= AluReg;
            WriteData <= AluData;
         end
      end
   end

   // Long-op payload storage; no reset needed, validity tracked by count.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_reg[wr_ptr]  <= LongReg;
         fifo_data[wr_ptr] <= LongData;
      end
   end

   // Pending mask: every occupied FIFO slot plus the write in flight.
   always_comb begin
      PendingMask = '0;
      slot_off    = '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
         slot_off = PTR_W'(i) - rd_ptr;
         if ({1'b0, slot_off} < count) begin
            PendingMask[fifo_reg[i]] = 1'b1;
         end
      end
      if (WriteEnable) begin
         PendingMask[WriteReg] = 1'b1;
      end
   end

`ifdef WB_FORWARD_EN
   // Bypass regfile read data while the matching write has not committed.
   always_comb begin
      OpA = (WriteEnable && (WriteReg == RegA)) ? WriteData : Data1;
      OpB = (WriteEnable && (WriteReg == RegB)) ? WriteData : Data2;
   end
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Bench for writeback_unit: directed vector table, hand sequences for
// starvation and mid-operation reset, then random traffic against a
// queue-based reference model.
module tb_writeback_unit;

   localparam int unsigned AW    = 5;
   localparam int unsigned DW    = 32;
   localparam int unsigned DEPTH = 4;
   localparam int          LIMIT = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic          AluValid;
   logic [AW-1:0] AluReg;
   logic [DW-1:0] AluData;
   logic          AluStall;
   logic          LongValid;
   logic          LongReady;
   logic [AW-1:0] LongReg;
   logic [DW-1:0] LongData;
   logic          WriteEnable;
   logic [AW-1:0] WriteReg;
   logic [DW-1:0] WriteData;
   logic [31:0]   PendingMask;
`ifdef WB_FORWARD_EN
   logic [AW-1:0] RegA, RegB;
   logic [DW-1:0] Data1, Data2, OpA, OpB;
`endif

   always #5 clk = ~clk;

   writeback_unit #(.FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT),
                    .REG_ADDR_SIZE(AW), .REG_SIZE(DW)) dut (
      .clk(clk), .reset(reset),
      .AluValid(AluValid), .AluReg(AluReg), .AluData(AluData), .AluStall(AluStall),
      .LongValid(LongValid), .LongReady(LongReady), .LongReg(LongReg), .LongData(LongData),
      .WriteEnable(WriteEnable), .WriteReg(WriteReg), .WriteData(WriteData),
      .PendingMask(PendingMask)
`ifdef WB_FORWARD_EN
      , .RegA(RegA), .RegB(RegB), .Data1(Data1), .Data2(Data2), .OpA(OpA), .OpB(OpB)
`endif
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a queue of buffered writes and the visible write port.
   typedef struct packed {
      logic [AW-1:0] r;
      logic [DW-1:0] d;
   } ent_t;

   ent_t          mq[$];
   int            m_age;
   logic          m_we;
   logic [AW-1:0] m_wr;
   logic [DW-1:0] m_wd;

   task automatic model_step();
      int   n;
      bit   popped;
      ent_t h;
      n = mq.size();
      popped = 0;
      if (reset) begin
         mq.delete();
         m_age = 0;
         m_we = 0;
         m_wr = '0;
         m_wd = '0;
         return;
      end
      if (m_age == LIMIT && n > 0) begin
         h = mq.pop_front(); popped = 1;
         m_we = 1; m_wr = h.r; m_wd = h.d;
      end else if (AluValid) begin
         m_we = 1; m_wr = AluReg; m_wd = AluData;
      end else if (n > 0) begin
         h = mq.pop_front(); popped = 1;
         m_we = 1; m_wr = h.r; m_wd = h.d;
      end else begin
         m_we = 0;
      end
      if (LongValid && n < int'(DEPTH)) mq.push_back({LongReg, LongData});
      if (popped || n == 0) m_age = 0;
      else if (m_age < LIMIT) m_age++;
   endtask

   task automatic check_model();
      logic [31:0] mask;
      mask = '0;
      foreach (mq[i]) mask[mq[i].r] = 1'b1;
      if (m_we) mask[m_wr] = 1'b1;
      chk("model_we", 32'(WriteEnable), 32'(m_we));
      if (m_we) begin
         chk("model_wr", 32'(WriteReg), 32'(m_wr));
         chk("model_wd", WriteData, m_wd);
      end
      chk("model_ready", 32'(LongReady), 32'(!reset && mq.size() < int'(DEPTH)));
      chk("model_stall", 32'(AluStall), 32'(m_age == LIMIT));
      chk("model_mask", PendingMask, mask);
`ifdef WB_FORWARD_EN
      chk("model_opa", OpA, (m_we && m_wr == RegA) ? m_wd : Data1);
      chk("model_opb", OpB, (m_we && m_wr == RegB) ? m_wd : Data2);
`endif
   endtask

   task automatic drive(input logic rst, input logic av, input logic [AW-1:0] ar,
                        input logic [DW-1:0] ad, input logic lv, input logic [AW-1:0] lr,
                        input logic [DW-1:0] ld);
      reset = rst; AluValid = av; AluReg = ar; AluData = ad;
      LongValid = lv; LongReg = lr; LongData = ld;
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      check_model();
   endtask

   typedef struct packed {
      logic          rst;
      logic          av;
      logic [AW-1:0] ar;
      logic [DW-1:0] ad;
      logic          lv;
      logic [AW-1:0] lr;
      logic [DW-1:0] ld;
      logic          e_we;
      logic [AW-1:0] e_wr;
      logic [DW-1:0] e_wd;
      logic          e_ready;
      logic [31:0]   e_mask;
   } vec_t;

   vec_t vecs[12];

   initial begin
      drive(1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
`ifdef WB_FORWARD_EN
      RegA = '0; RegB = '0; Data1 = '0; Data2 = '0;
`endif

      // rst av ar ad lv lr ld | we wr wd ready mask
      vecs[0]  = '{1'b1, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 5'd0,  32'h0,        1'b0, 32'h0};
      vecs[1]  = '{1'b0, 1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0, 32'h0,  1'b1, 5'd5,  32'hDEADBEEF, 1'b1, 32'h0000_0020};
      vecs[2]  = '{1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 5'd5,  32'hDEADBEEF, 1'b1, 32'h0};
      vecs[3]  = '{1'b0, 1'b1, 5'd20, 32'hA0,       1'b1, 5'd1, 32'h11, 1'b1, 5'd20, 32'hA0,       1'b1, 32'h0010_0002};
      vecs[4]  = '{1'b0, 1'b1, 5'd20, 32'hA1,       1'b1, 5'd2, 32'h22, 1'b1, 5'd20, 32'hA1,       1'b1, 32'h0010_0006};
      vecs[5]  = '{1'b0, 1'b1, 5'd20, 32'hA2,       1'b1, 5'd3, 32'h33, 1'b1, 5'd20, 32'hA2,       1'b1, 32'h0010_000E};
      vecs[6]  = '{1'b0, 1'b1, 5'd20, 32'hA3,       1'b1, 5'd4, 32'h44, 1'b1, 5'd20, 32'hA3,       1'b0, 32'h0010_001E};
      vecs[7]  = '{1'b0, 1'b0, 5'd0,  32'h0,        1'b1, 5'd9, 32'h99, 1'b1, 5'd1,  32'h11,       1'b1, 32'h0000_001E};
      vecs[8]  = '{1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,  1'b1, 5'd2,  32'h22,       1'b1, 32'h0000_001C};
      vecs[9]  = '{1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,  1'b1, 5'd3,  32'h33,       1'b1, 32'h0000_0018};
      vecs[10] = '{1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,  1'b1, 5'd4,  32'h44,       1'b1, 32'h0000_0010};
      vecs[11] = '{1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 5'd4,  32'h44,       1'b1, 32'h0};

      // Directed table: ALU write, FIFO fill behind ALU, refused push on full, drain.
      for (int i = 0; i < 12; i++) begin
         drive(vecs[i].rst, vecs[i].av, vecs[i].ar, vecs[i].ad,
               vecs[i].lv, vecs[i].lr, vecs[i].ld);
         tick();
         chk($sformatf("tbl%0d_we", i),    32'(WriteEnable), 32'(vecs[i].e_we));
         chk($sformatf("tbl%0d_wr", i),    32'(WriteReg),    32'(vecs[i].e_wr));
         chk($sformatf("tbl%0d_wd", i),    WriteData,        vecs[i].e_wd);
         chk($sformatf("tbl%0d_ready", i), 32'(LongReady),   32'(vecs[i].e_ready));
         chk($sformatf("tbl%0d_mask", i),  PendingMask,      vecs[i].e_mask);
      end

      // Starvation: ALU held busy, one long-op to reg 9 must break through.
      drive(1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
      tick();
      drive(1'b0, 1'b1, 5'd3, 32'h300, 1'b1, 5'd9, 32'h900);
      tick();
      chk("starve_push_stall", 32'(AluStall), 32'd0);
      chk("starve_push_mask", PendingMask, 32'h0000_0208);
      for (int k = 1; k <= 10; k++) begin
         drive(1'b0, 1'b1, 5'd3, 32'h300 + 32'(k), 1'b0, '0, '0);
         tick();
         chk($sformatf("starve%0d_stall", k), 32'(AluStall), 32'(k == 8));
         chk($sformatf("starve%0d_wr", k), 32'(WriteReg), (k == 9) ? 32'd9 : 32'd3);
         if (k == 9)  chk("starve_wd9", WriteData, 32'h900);
         if (k == 10) chk("starve_wd10", WriteData, 32'h30A);
      end

      // Reset while three long-ops are buffered: nothing gets written.
      for (int j = 0; j < 3; j++) begin
         drive(1'b0, 1'b1, 5'd1, 32'h1, 1'b1, 5'(10 + j), 32'(j));
         tick();
      end
      chk("rstmid_mask_before", PendingMask, 32'h0000_1C02);
      for (int j = 0; j < 2; j++) begin
         drive(1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
         tick();
         chk("rstmid_we", 32'(WriteEnable), 32'd0);
         chk("rstmid_mask", PendingMask, 32'd0);
         chk("rstmid_ready", 32'(LongReady), 32'd0);
         chk("rstmid_stall", 32'(AluStall), 32'd0);
      end
      for (int j = 0; j < 4; j++) begin
         drive(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
         tick();
         chk("postrst_we", 32'(WriteEnable), 32'd0);
         chk("postrst_ready", 32'(LongReady), 32'd1);
         chk("postrst_wr", 32'(WriteReg), 32'd0);
      end

`ifdef WB_FORWARD_EN
      // Forwarding of the write in flight.
      drive(1'b0, 1'b1, 5'd7, 32'h1234, 1'b0, '0, '0);
      tick();
      RegA = 5'd7; Data1 = 32'h0; RegB = 5'd8; Data2 = 32'h5555;
      #1;
      chk("fwd_opa", OpA, 32'h1234);
      chk("fwd_opb", OpB, 32'h5555);
`endif

      // Random traffic against the model, with occasional reset.
      for (int c = 0; c < 3000; c++) begin
         drive(1'($urandom_range(0, 99) == 0),
               1'($urandom_range(0, 9) < 7), AW'($urandom_range(0, 31)), $urandom,
               1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), $urandom);
`ifdef WB_FORWARD_EN
         RegA = AW'($urandom_range(0, 31)); RegB = AW'($urandom_range(0, 31));
         Data1 = $urandom; Data2 = $urandom;
`endif
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
